// File: rtl/barrel_shifter_pkg.sv
// Shared encodings for the barrel shifter: operation modes and shift direction.
package barrel_shifter_pkg;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_stage.sv
// One fixed-distance stage of the barrel shifter: passes d through, or shifts or
// rotates it by DIST when en is set.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] rot_l;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] lsh_l;
  logic [WIDTH-1:0] lsh_r;
  logic [WIDTH-1:0] ash_r;

  assign rot_l = (d << DIST) | (d >> (WIDTH - DIST));
  assign rot_r = (d >> DIST) | (d << (WIDTH - DIST));
  assign lsh_l = d << DIST;
  assign lsh_r = d >> DIST;
  // Chained stages keep the original sign bit in the MSB, so each stage may
  // replicate its own input MSB.
  assign ash_r = $signed(d) >>> DIST;

  always_comb begin
    q = d;
    if (en) begin
      case (mode)
        MODE_LSL: q = (dir == DIR_LEFT) ? lsh_l : lsh_r;
        MODE_ASR: q = (dir == DIR_LEFT) ? lsh_l : ash_r;
        MODE_ROT, MODE_RSV: q = (dir == DIR_RIGHT) ? rot_r : rot_l;
        default: q = d;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// Registered barrel shifter: SEL_W conditional power-of-two stages feeding a
// single output register bank, one result per accepted input.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [SEL_W-1:0] sel,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] shift_out,
  output logic             out_valid
);

  logic [SEL_W:0][WIDTH-1:0] stage_d;

  assign stage_d[0] = a;

  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .d    (stage_d[k]),
      .en   (sel[k]),
      .dir  (dir),
      .mode (mode),
      .q    (stage_d[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) shift_out <= stage_d[SEL_W];
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: bit-level reference model checked every
// cycle, plus literal expectations for the documented vectors.
module tb_barrel_shifter;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [S-1:0] sel = '0;
  logic         dir = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] shift_out;
  logic         out_valid;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_out = '0;
  logic         exp_valid = 1'b0;

  barrel_shifter #(.WIDTH(W), .SEL_W(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .sel       (sel),
    .dir       (dir),
    .mode      (mode),
    .in_valid  (in_valid),
    .shift_out (shift_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference: each result bit names its source bit and decides the fill.
  function automatic logic [W-1:0] model(input logic [W-1:0] av, input int s,
                                         input logic d, input logic [1:0] m);
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (d == 1'b0) begin
        src = i - s;
        if (src >= 0) r[i] = av[src];
        else if (m == 2'b01 || m == 2'b10) r[i] = 1'b0;
        else r[i] = av[src + W];
      end else begin
        src = i + s;
        if (src < W) r[i] = av[src];
        else if (m == 2'b01) r[i] = 1'b0;
        else if (m == 2'b10) r[i] = av[W-1];
        else r[i] = av[src - W];
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) exp_out = model(a, int'(sel), dir, mode);
    end
  end

  always @(negedge clk) begin
    tests++;
    if (out_valid !== exp_valid || shift_out !== exp_out) begin
      fails++;
      $display("FAIL cycle_compare t=%0t: got out=%b valid=%b, expected out=%b valid=%b",
               $time, shift_out, out_valid, exp_out, exp_valid);
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // Called at a negedge; presents one valid input and checks the result one cycle later.
  task automatic apply(input string name, input logic [W-1:0] av, input logic [S-1:0] s,
                       input logic d, input logic [1:0] m, input logic [W-1:0] want);
    a = av; sel = s; dir = d; mode = m; in_valid = 1'b1;
    @(negedge clk);
    check(name, shift_out, want);
    check1({name, "_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    check("model_rotl1", model(4'b1101, 1, 1'b0, 2'b00), 4'b1011);
    check("model_rotr1", model(4'b1101, 1, 1'b1, 2'b00), 4'b1110);
    check("model_asr2",  model(4'b1101, 2, 1'b1, 2'b10), 4'b1111);
    check("model_lsr3",  model(4'b1101, 3, 1'b1, 2'b01), 4'b0001);

    #1;
    check("reset_out", shift_out, 4'b0000);
    check1("reset_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    apply("rot_1101_s0", 4'b1101, 2'd0, 1'b0, 2'b00, 4'b1101);
    apply("rot_1101_s1", 4'b1101, 2'd1, 1'b0, 2'b00, 4'b1011);
    apply("rot_1101_s2", 4'b1101, 2'd2, 1'b0, 2'b00, 4'b0111);
    apply("rot_1101_s3", 4'b1101, 2'd3, 1'b0, 2'b00, 4'b1110);
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_1", shift_out, 4'b1110);
    check1("hold_1_valid", out_valid, 1'b0);
    a = 4'b0000; sel = 2'd1;
    @(negedge clk);
    check("hold_2", shift_out, 4'b1110);

    apply("rot_0110_s0", 4'b0110, 2'd0, 1'b0, 2'b00, 4'b0110);
    apply("rot_0110_s1", 4'b0110, 2'd1, 1'b0, 2'b00, 4'b1100);
    apply("rot_0110_s2", 4'b0110, 2'd2, 1'b0, 2'b00, 4'b1001);
    apply("rot_0110_s3", 4'b0110, 2'd3, 1'b0, 2'b00, 4'b0011);
    apply("lsr_1101_s1", 4'b1101, 2'd1, 1'b1, 2'b01, 4'b0110);
    apply("asr_1101_s2", 4'b1101, 2'd2, 1'b1, 2'b10, 4'b1111);
    apply("lsl_1101_s3", 4'b1101, 2'd3, 1'b0, 2'b01, 4'b1000);
    apply("rsv_1101_s1", 4'b1101, 2'd1, 1'b0, 2'b11, 4'b1011);
    apply("asl_0111_s1", 4'b0111, 2'd1, 1'b0, 2'b10, 4'b1110);
    apply("rotr_1001_s1", 4'b1001, 2'd1, 1'b1, 2'b00, 4'b1100);
    apply("asr_0110_s1", 4'b0110, 2'd1, 1'b1, 2'b10, 4'b0011);
    apply("lsr_1111_s0", 4'b1111, 2'd0, 1'b1, 2'b01, 4'b1111);

    // Input changes after the sampling edge must not reach the output.
    a = 4'b1000; sel = 2'd1; dir = 1'b1; mode = 2'b01; in_valid = 1'b1;
    @(posedge clk);
    #2;
    a = 4'b0111; sel = 2'd0; in_valid = 1'b0;
    @(negedge clk);
    check("mid_cycle_change", shift_out, 4'b0100);

    // Asynchronous reset while a result is being presented.
    apply("pre_reset", 4'b1101, 2'd1, 1'b0, 2'b00, 4'b1011);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", shift_out, 4'b0000);
    check1("async_reset_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply("post_reset", 4'b0110, 2'd2, 1'b1, 2'b00, 4'b1001);

    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      sel = S'($urandom);
      dir = 1'($urandom);
      mode = 2'($urandom);
      in_valid = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
